// File: rtl/fetch_ctrl.sv
// fetch_ctrl: dual-word instruction fetch into a DEPTH-entry queue with stall, halt and redirect.
//   clk, rst (async, active-high)            clock and reset
//   start, redirect, redirect_pc             leave IDLE / flush and reload PC
//   deq                                      words consumed by decode (0..2)
//   Dato_Instru_1/2 <- Dir_Instru_1/2        combinational memory at PC and PC+4
//   ReadMem_1/2                              active-low read enables, low in a fetch cycle
//   inst0/inst1/inst0_pc, valid0/valid1      queue head view
//   count, state                             occupancy and IDLE=0 FETCH=1 STALL=2 HALT=3
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00400000,
    parameter int          DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic [1:0]               deq,
    input  logic [31:0]              Dato_Instru_1,
    input  logic [31:0]              Dato_Instru_2,
    output logic [31:0]              Dir_Instru_1,
    output logic [31:0]              Dir_Instru_2,
    output logic                     ReadMem_1,
    output logic                     ReadMem_2,
    output logic [31:0]              inst0,
    output logic [31:0]              inst1,
    output logic [31:0]              inst0_pc,
    output logic                     valid0,
    output logic                     valid1,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] HALT_WORD = 32'hFFFFFFFF;

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, STALL = 2'd2, HALT = 2'd3} state_t;

    state_t         st, st_next;
    logic [31:0]    pc, pc_next;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  cnt, cnt_next, free, free_next;
    logic [31:0]    word_q [DEPTH];
    logic [31:0]    pc_q   [DEPTH];
    logic           flush, fetch, halt1, halt2;
    logic [1:0]     pushes, pops;

    assign flush     = redirect && st != IDLE;
    assign free      = CW'(DEPTH) - cnt;
    assign fetch     = st == FETCH && !redirect && free >= CW'(2);
    assign halt1     = Dato_Instru_1 == HALT_WORD;
    assign halt2     = Dato_Instru_2 == HALT_WORD;
    // A halt word truncates the pair: nothing after it enters the queue.
    assign pushes    = !fetch ? 2'd0 : halt1 ? 2'd0 : halt2 ? 2'd1 : 2'd2;
    // Pops are clamped to occupancy; when deq exceeds cnt, cnt fits in two bits.
    assign pops      = flush ? 2'd0 : (CW'(deq) > cnt) ? cnt[1:0] : deq;
    assign cnt_next  = flush ? '0 : cnt - CW'(pops) + CW'(pushes);
    assign free_next = CW'(DEPTH) - cnt_next;
    assign pc_next   = flush ? (redirect_pc & ~32'h3) : pc + {28'd0, pushes, 2'b00};

    always_comb begin
        st_next = st;
        if (flush)
            st_next = FETCH;
        else
            case (st)
                IDLE:    st_next = start ? FETCH : IDLE;
                FETCH:   st_next = (fetch && (halt1 || halt2)) ? HALT : !fetch ? STALL : FETCH;
                STALL:   st_next = (free_next >= CW'(2)) ? FETCH : STALL;
                default: st_next = HALT;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            st     <= IDLE;
        end else begin
            pc     <= pc_next;
            cnt    <= cnt_next;
            rd_ptr <= flush ? '0 : rd_ptr + AW'(pops);
            wr_ptr <= flush ? '0 : wr_ptr + AW'(pushes);
            st     <= st_next;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (pushes != 2'd0) begin
            word_q[wr_ptr] <= Dato_Instru_1;
            pc_q[wr_ptr]   <= pc;
        end
        if (pushes == 2'd2) begin
            word_q[wr_ptr + AW'(1)] <= Dato_Instru_2;
            pc_q[wr_ptr + AW'(1)]   <= pc + 32'd4;
        end
    end

    assign Dir_Instru_1 = pc;
    assign Dir_Instru_2 = pc + 32'd4;
    assign ReadMem_1    = !fetch;
    assign ReadMem_2    = !fetch;
    assign inst0        = word_q[rd_ptr];
    assign inst1        = word_q[rd_ptr + AW'(1)];
    assign inst0_pc     = pc_q[rd_ptr];
    assign valid0       = cnt >= CW'(1);
    assign valid1       = cnt >= CW'(2);
    assign count        = cnt;
    assign state        = st;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table, directed and random checks of fetch_ctrl against a queue-based model.
module tb_fetch_ctrl;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h00400000;
    localparam logic [31:0] HALT_W   = 32'hFFFFFFFF;
    localparam int S_IDLE = 0, S_FETCH = 1, S_STALL = 2, S_HALT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [1:0]  deq = '0;
    logic [31:0] d1, d2, a1, a2, inst0, inst1, inst0_pc;
    logic        rm1, rm2, valid0, valid1;
    logic [3:0]  count;
    logic [1:0]  state;
    logic [31:0] halt_addr = 32'h3;

    fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .redirect(redirect), .redirect_pc(redirect_pc),
        .deq(deq), .Dato_Instru_1(d1), .Dato_Instru_2(d2), .Dir_Instru_1(a1), .Dir_Instru_2(a2),
        .ReadMem_1(rm1), .ReadMem_2(rm2), .inst0(inst0), .inst1(inst1), .inst0_pc(inst0_pc),
        .valid0(valid0), .valid1(valid1), .count(count), .state(state)
    );

    always #5 clk = ~clk;

    // Memory: address-derived words, never all-ones at an aligned address unless halt_addr.
    assign d1 = (a1 == halt_addr) ? HALT_W : {a1[15:0], 16'hC0DE};
    assign d2 = (a2 == halt_addr) ? HALT_W : {a2[15:0], 16'hC0DE};

    typedef struct { logic [31:0] w; logic [31:0] a; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    int          m_st;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic s; logic r; logic [31:0] rp; logic [1:0] dq;
        int exp_count; int exp_state; logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == halt_addr) ? HALT_W : {a[15:0], 16'hC0DE};
    endfunction

    function automatic logic exp_fetch(input logic r);
        return m_st == S_FETCH && !r && (DEPTH - mq.size()) >= 2;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc = RESET_PC;
        m_st = S_IDLE;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] rp, input logic [1:0] dq);
        int room, pops;
        logic [31:0] w1, w2;
        room = DEPTH - mq.size();
        if (m_st == S_IDLE) begin
            if (s) m_st = S_FETCH;
        end else if (r) begin
            mq.delete();
            m_pc = rp & ~32'h3;
            m_st = S_FETCH;
        end else begin
            pops = (int'(dq) > mq.size()) ? mq.size() : int'(dq);
            repeat (pops) void'(mq.pop_front());
            if (m_st == S_FETCH && room >= 2) begin
                w1 = memf(m_pc);
                w2 = memf(m_pc + 32'd4);
                if (w1 == HALT_W) m_st = S_HALT;
                else begin
                    mq.push_back('{w1, m_pc});
                    if (w2 == HALT_W) begin
                        m_pc += 32'd4;
                        m_st = S_HALT;
                    end else begin
                        mq.push_back('{w2, m_pc + 32'd4});
                        m_pc += 32'd8;
                    end
                end
            end else if (m_st == S_FETCH) m_st = S_STALL;
            else if (m_st == S_STALL && DEPTH - mq.size() >= 2) m_st = S_FETCH;
        end
    endtask

    task automatic check_outputs();
        chk("count", count, mq.size());
        chk("state", state, m_st);
        chk("dir1", a1, m_pc);
        chk("dir2", a2, m_pc + 32'd4);
        chk("valid0", valid0, mq.size() >= 1);
        chk("valid1", valid1, mq.size() >= 2);
        if (mq.size() >= 1) begin
            chk("inst0", inst0, mq[0].w);
            chk("inst0_pc", inst0_pc, mq[0].a);
        end
        if (mq.size() >= 2) chk("inst1", inst1, mq[1].w);
    endtask

    task automatic cycle(input logic s, input logic r, input logic [31:0] rp, input logic [1:0] dq);
        start = s; redirect = r; redirect_pc = rp; deq = dq;
        #1;
        chk("readmem", {rm1, rm2}, {2{!exp_fetch(r)}});
        @(posedge clk);
        model_step(s, r, rp, dq);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; redirect = 1'b0; deq = '0; redirect_pc = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs();
        chk("reset_readmem", {rm1, rm2}, 2'b11);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0, 2'd0, 0, S_FETCH, 32'h00400000};
        tbl[1] = '{1'b0, 1'b0, 32'h0, 2'd0, 2, S_FETCH, 32'h00400008};
        tbl[2] = '{1'b0, 1'b0, 32'h0, 2'd0, 4, S_FETCH, 32'h00400010};
        tbl[3] = '{1'b0, 1'b0, 32'h0, 2'd0, 6, S_FETCH, 32'h00400018};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 2'd0, 8, S_FETCH, 32'h00400020};
        tbl[5] = '{1'b0, 1'b0, 32'h0, 2'd0, 8, S_STALL, 32'h00400020};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 2'd2, 6, S_FETCH, 32'h00400020};
        tbl[7] = '{1'b0, 1'b0, 32'h0, 2'd0, 8, S_FETCH, 32'h00400028};
        tbl[8] = '{1'b0, 1'b0, 32'h0, 2'd0, 8, S_STALL, 32'h00400028};

        do_reset();
        cycle(1'b0, 1'b1, 32'h00001234, 2'd0);
        chk("idle_redirect_pc", a1, RESET_PC);
        chk("idle_redirect_state", state, S_IDLE);

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].s, tbl[i].r, tbl[i].rp, tbl[i].dq);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].exp_state);
            chk($sformatf("tbl%0d_pc", i), a1, tbl[i].exp_pc);
        end
        cycle(1'b0, 1'b0, 32'h0, 2'd0);
        chk("full_readmem", {rm1, rm2}, 2'b11);

        cycle(1'b0, 1'b1, 32'h00400102, 2'd1);
        chk("redirect_align", a1, 32'h00400100);
        cycle(1'b0, 1'b0, 32'h0, 2'd0);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 2'd2);
            chk("steady_pc", inst0_pc, 32'h00400100 + 32'(8 * k));
            chk("steady_count", count, 4'd2);
            chk("steady_state", state, S_FETCH);
        end

        halt_addr = 32'h00400074;
        cycle(1'b0, 1'b1, 32'h00400070, 2'd0);
        cycle(1'b0, 1'b0, 32'h0, 2'd0);
        chk("halt2_count", count, 4'd1);
        chk("halt2_pc", a1, 32'h00400074);
        chk("halt2_inst0_pc", inst0_pc, 32'h00400070);
        chk("halt2_state", state, S_HALT);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 2'd0);
        chk("halt2_hold", {rm1, rm2, state}, {2'b11, 2'd3});
        cycle(1'b0, 1'b1, 32'h00400086, 2'd0);
        chk("halt2_exit_count", count, 4'd0);
        chk("halt2_exit_pc", a1, 32'h00400084);
        chk("halt2_exit_state", state, S_FETCH);

        halt_addr = 32'h00400200;
        cycle(1'b0, 1'b1, 32'h00400200, 2'd0);
        cycle(1'b0, 1'b0, 32'h0, 2'd1);
        chk("halt1_count", count, 4'd0);
        chk("halt1_pc", a1, 32'h00400200);
        chk("halt1_state", state, S_HALT);
        halt_addr = 32'h3;

        cycle(1'b0, 1'b1, 32'h00400300, 2'd0);
        cycle(1'b0, 1'b0, 32'h0, 2'd0);
        cycle(1'b0, 1'b0, 32'h0, 2'd0);
        cycle(1'b0, 1'b0, 32'h0, 2'd1);
        chk("five_count", count, 4'd5);
        cycle(1'b0, 1'b1, 32'h00400400, 2'd2);
        chk("flush_count", count, 4'd0);
        chk("flush_valid0", valid0, 1'b0);
        chk("flush_pc", a1, 32'h00400400);

        cycle(1'b0, 1'b0, 32'h0, 2'd0);
        cycle(1'b0, 1'b0, 32'h0, 2'd0);
        chk("pre_rst_count", count, 4'd4);
        start = 1'b0; redirect = 1'b0; deq = 2'd0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_count", count, 4'd0);
        chk("async_state", state, S_IDLE);
        chk("async_valid", {valid0, valid1}, 2'b00);
        chk("async_readmem", {rm1, rm2}, 2'b11);
        chk("async_pc", a1, RESET_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs();

        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) halt_addr = ($urandom % 2 == 0) ? m_pc + 32'(4 * $urandom_range(0, 16)) : 32'h3;
            if ($urandom % 500 == 0) do_reset();
            else cycle($urandom % 8 != 0, $urandom % 16 == 0,
                       32'h00400000 + ($urandom & 32'h0000FFFF), 2'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
